mc_controller: RTL and testbench

//  Multicycle MIPS control FSM, directly upstream of the ALU decoder: decodes op, sequences fetch/decode/execute/memory/writeback.

---
 rtl/mc_controller.sv | 203 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables/selects plus the 4-bit aluop consumed by the ALU decoder.
// Memory accesses stall on i_mem_ready. A bounded wait counter turns a stuck
// access into a one-cycle o_mem_err pulse and a return to FETCH.
module mc_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic       i_mem_ready,
  output logic       o_pcwrite,
  output logic       o_branch,
  output logic       o_irwrite,
  output logic       o_memwrite,
  output logic       o_regwrite,
  output logic       o_iord,
  output logic       o_memtoreg,
  output logic       o_regdst,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic       o_immext,
  output logic [1:0] o_pcsrc,
  output logic [3:0] o_aluop,
  output logic       o_illegal,
  output logic       o_mem_err
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit TO_ENABLE = (TIMEOUT_CYCLES != 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEX, S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_waitCnt;
  logic          w_waitState;
  logic          w_timeout;
  logic          w_illegal;

  // Only FETCH, MEMRD and MEMWR wait on memory; a timeout fires once the
  // counter has reached the limit and memory is still not ready.
  assign w_waitState = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout   = TO_ENABLE && w_waitState && !i_mem_ready && (r_waitCnt == TO_VAL);

  // Next-state decode; op is only consulted where the IR is known stable.
  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ready) w_next = S_DECODE;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = S_RTEX;
          OP_BEQ, OP_BLEZ: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: w_next = S_IMMEX;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: w_next = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (i_mem_ready) w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWB: w_next = S_FETCH;
      S_MEMWR: begin
        if (i_mem_ready || w_timeout) w_next = S_FETCH;
      end
      S_RTEX:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // State register and saturating wait counter, cleared on any state entry or timeout.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_waitCnt <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_timeout) begin
        r_waitCnt <= '0;
      end else if (w_waitState && !i_mem_ready && (r_waitCnt != CNT_MAX)) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
    end
  end

  // Moore output decode; memory-dependent strobes are qualified by mem_ready and reset masks all strobes.
  always_comb begin
    o_pcwrite  = 1'b0;
    o_branch   = 1'b0;
    o_irwrite  = 1'b0;
    o_memwrite = 1'b0;
    o_regwrite = 1'b0;
    o_iord     = 1'b0;
    o_memtoreg = 1'b0;
    o_regdst   = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = 2'b00;
    o_immext   = 1'b0;
    o_pcsrc    = 2'b00;
    o_aluop    = 4'b0000;
    o_illegal  = w_illegal;
    o_mem_err  = w_timeout;
    case (r_state)
      S_FETCH: begin
        o_alusrcb = 2'b01;
        o_irwrite = i_mem_ready;
        o_pcwrite = i_mem_ready;
      end
      S_DECODE: o_alusrcb = 2'b11;
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
      end
      S_MEMRD: o_iord = 1'b1;
      S_MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = i_mem_ready;
      end
      S_RTEX: begin
        o_alusrca = 1'b1;
        o_aluop   = 4'b1111;
      end
      S_ALUWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      S_IMMEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        case (i_op)
          OP_SLTI: o_aluop = 4'b0110;
          OP_ORI:  o_aluop = 4'b0011;
          OP_XORI: o_aluop = 4'b0101;
          OP_ANDI: o_aluop = 4'b0111;
          OP_LUI:  o_aluop = 4'b0100;
          default: o_aluop = 4'b0000;
        endcase
        o_immext = (i_op == OP_ANDI) || (i_op == OP_ORI) || (i_op == OP_XORI);
      end
      S_IMMWB: o_regwrite = 1'b1;
      S_BRANCH: begin
        o_alusrca = 1'b1;
        o_pcsrc   = 2'b01;
        o_branch  = 1'b1;
        o_aluop   = (i_op == OP_BLEZ) ? 4'b0010 : 4'b0001;
      end
      S_JUMP: begin
        o_pcsrc   = 2'b10;
        o_pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (i_reset) begin
      o_pcwrite  = 1'b0;
      o_branch   = 1'b0;
      o_irwrite  = 1'b0;
      o_memwrite = 1'b0;
      o_regwrite = 1'b0;
      o_illegal  = 1'b0;
      o_mem_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vector table for the documented scenarios, then
// randomized instruction streams checked against a step-list reference model.
module tb_mc_controller;

  localparam int TO = 4;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immext;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       illegal;
    logic       memErr;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, memReady;
  logic [5:0] op;
  logic pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic immext, illegal, memErr;
  logic [3:0] aluop;
  outs_t got;

  int tests = 0;
  int fails = 0;

  vec_t vec[$];
  string step;
  string path[$];
  int waits;
  logic [5:0] legalOps[12];

  mc_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_mem_ready(memReady),
    .o_pcwrite(pcwrite), .o_branch(branch), .o_irwrite(irwrite),
    .o_memwrite(memwrite), .o_regwrite(regwrite), .o_iord(iord),
    .o_memtoreg(memtoreg), .o_regdst(regdst), .o_alusrca(alusrca),
    .o_alusrcb(alusrcb), .o_immext(immext), .o_pcsrc(pcsrc),
    .o_aluop(aluop), .o_illegal(illegal), .o_mem_err(memErr)
  );

  always #5 clk = ~clk;

  // Gather the DUT outputs into one record for whole-vector comparison.
  always_comb begin
    got.pcwrite  = pcwrite;
    got.branch   = branch;
    got.irwrite  = irwrite;
    got.memwrite = memwrite;
    got.regwrite = regwrite;
    got.iord     = iord;
    got.memtoreg = memtoreg;
    got.regdst   = regdst;
    got.alusrca  = alusrca;
    got.alusrcb  = alusrcb;
    got.immext   = immext;
    got.pcsrc    = pcsrc;
    got.aluop    = aluop;
    got.illegal  = illegal;
    got.memErr   = memErr;
  end

  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic m);
    reset    = r;
    op       = o;
    memReady = m;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%05h exp=%05h", name, got, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic [5:0] o, input logic m, input outs_t e);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = m; v.exp = e;
    vec.push_back(v);
  endtask

  function automatic bit isLegal(input logic [5:0] o);
    for (int k = 0; k < 12; k++) if (legalOps[k] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit isWait(input string s);
    return (s == "FETCH") || (s == "MEMRD") || (s == "MEMWR");
  endfunction

  // Reference: expected outputs for an instruction step, straight from the control table.
  function automatic outs_t expOut(input string s, input logic [5:0] o, input logic m,
                                   input logic r, input int w);
    outs_t e;
    e = '0;
    case (s)
      "FETCH":  begin e.alusrcb = 2'b01; e.irwrite = m; e.pcwrite = m; end
      "DECODE": begin e.alusrcb = 2'b11; e.illegal = !isLegal(o); end
      "MEMADR": begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      "MEMRD":  e.iord = 1'b1;
      "MEMWB":  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      "MEMWR":  begin e.iord = 1'b1; e.memwrite = m; end
      "RTEX":   begin e.alusrca = 1'b1; e.aluop = 4'hF; end
      "ALUWB":  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      "IMMEX": begin
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        e.aluop = (o == 6'h0A) ? 4'd6 : (o == 6'h0D) ? 4'd3 : (o == 6'h0E) ? 4'd5 :
                  (o == 6'h0C) ? 4'd7 : (o == 6'h0F) ? 4'd4 : 4'd0;
        e.immext = (o == 6'h0C) || (o == 6'h0D) || (o == 6'h0E);
      end
      "IMMWB":  e.regwrite = 1'b1;
      "BRANCH": begin
        e.alusrca = 1'b1; e.pcsrc = 2'b01; e.branch = 1'b1;
        e.aluop = (o == 6'h06) ? 4'd2 : 4'd1;
      end
      "JUMP":   begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
      default: ;
    endcase
    e.memErr = isWait(s) && !m && (w >= TO);
    if (r) begin
      e.pcwrite = 0; e.branch = 0; e.irwrite = 0; e.memwrite = 0;
      e.regwrite = 0; e.illegal = 0; e.memErr = 0;
    end
    return e;
  endfunction

  // Reference: advance one clock through the instruction's list of remaining steps.
  task automatic modelStep(input logic r, input logic [5:0] o, input logic m);
    if (r) begin
      step = "FETCH"; waits = 0; path.delete();
    end else if (isWait(step) && !m) begin
      if (waits >= TO) begin
        step = "FETCH"; waits = 0; path.delete();
      end else begin
        waits++;
      end
    end else begin
      waits = 0;
      if (step == "FETCH") begin
        step = "DECODE";
      end else begin
        if (step == "DECODE") begin
          case (o)
            6'h23: path = '{"MEMADR", "MEMRD", "MEMWB"};
            6'h2B: path = '{"MEMADR", "MEMWR"};
            6'h00: path = '{"RTEX", "ALUWB"};
            6'h04, 6'h06: path = '{"BRANCH"};
            6'h02: path = '{"JUMP"};
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: path = '{"IMMEX", "IMMWB"};
            default: path.delete();
          endcase
        end
        if (path.size() > 0) step = path.pop_front();
        else step = "FETCH";
      end
    end
  endtask

  initial begin
    outs_t cFR, cFW, cDec, cDecIll, cRtex, cAluwb, cMemadr, cMemrd, cMemwb;
    outs_t cMwWait, cMwTmo, cMwRdy, cOri, cImmwb, cBlez, cJump;
    logic r, m;
    logic [5:0] o;
    int lowRun;

    legalOps = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h06, 6'h02,
                 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    cFW = '0; cFW.alusrcb = 2'b01;
    cFR = cFW; cFR.irwrite = 1; cFR.pcwrite = 1;
    cDec = '0; cDec.alusrcb = 2'b11;
    cDecIll = cDec; cDecIll.illegal = 1;
    cRtex = '0; cRtex.alusrca = 1; cRtex.aluop = 4'b1111;
    cAluwb = '0; cAluwb.regdst = 1; cAluwb.regwrite = 1;
    cMemadr = '0; cMemadr.alusrca = 1; cMemadr.alusrcb = 2'b10;
    cMemrd = '0; cMemrd.iord = 1;
    cMemwb = '0; cMemwb.memtoreg = 1; cMemwb.regwrite = 1;
    cMwWait = '0; cMwWait.iord = 1;
    cMwTmo = cMwWait; cMwTmo.memErr = 1;
    cMwRdy = cMwWait; cMwRdy.memwrite = 1;
    cOri = cMemadr; cOri.aluop = 4'b0011; cOri.immext = 1;
    cImmwb = '0; cImmwb.regwrite = 1;
    cBlez = '0; cBlez.alusrca = 1; cBlez.pcsrc = 2'b01; cBlez.branch = 1; cBlez.aluop = 4'b0010;
    cJump = '0; cJump.pcsrc = 2'b10; cJump.pcwrite = 1;

    addVec(1, 6'h00, 1, cFW);
    addVec(0, 6'h00, 1, cFR);    addVec(0, 6'h00, 1, cDec);
    addVec(0, 6'h00, 1, cRtex);  addVec(0, 6'h00, 1, cAluwb);
    addVec(0, 6'h23, 1, cFR);    addVec(0, 6'h23, 1, cDec);   addVec(0, 6'h23, 1, cMemadr);
    for (int k = 0; k < 3; k++) addVec(0, 6'h23, 0, cMemrd);
    addVec(0, 6'h23, 1, cMemrd); addVec(0, 6'h23, 1, cMemwb);
    addVec(0, 6'h0D, 1, cFR);    addVec(0, 6'h0D, 1, cDec);
    addVec(0, 6'h0D, 1, cOri);   addVec(0, 6'h0D, 1, cImmwb);
    addVec(0, 6'h06, 1, cFR);    addVec(0, 6'h06, 1, cDec);   addVec(0, 6'h06, 1, cBlez);
    addVec(0, 6'h3F, 1, cFR);    addVec(0, 6'h3F, 1, cDecIll);
    addVec(0, 6'h2B, 0, cFW);
    addVec(0, 6'h2B, 1, cFR);    addVec(0, 6'h2B, 1, cDec);   addVec(0, 6'h2B, 1, cMemadr);
    for (int k = 0; k < 4; k++) addVec(0, 6'h2B, 0, cMwWait);
    addVec(0, 6'h2B, 0, cMwTmo);
    addVec(0, 6'h2B, 1, cFR);    addVec(0, 6'h2B, 1, cDec);   addVec(0, 6'h2B, 1, cMemadr);
    addVec(1, 6'h2B, 1, cMwWait);
    addVec(0, 6'h2B, 0, cFW);
    addVec(0, 6'h2B, 1, cFR);    addVec(0, 6'h2B, 1, cDec);   addVec(0, 6'h2B, 1, cMemadr);
    for (int k = 0; k < 4; k++) addVec(0, 6'h2B, 0, cMwWait);
    addVec(0, 6'h2B, 1, cMwRdy);
    addVec(0, 6'h02, 0, cFW);
    addVec(0, 6'h02, 1, cFR);    addVec(0, 6'h02, 1, cDec);
    addVec(0, 6'h02, 1, cJump);  addVec(0, 6'h02, 1, cFR);

    applyStimulus(1, 6'h00, 1);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vec.size(); i++) begin
      applyStimulus(vec[i].rst, vec[i].op, vec[i].rdy);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vec[i].exp);
      @(posedge clk);
      #1;
    end

    applyStimulus(1, 6'h00, 1);
    @(posedge clk);
    #1;
    step = "FETCH";
    waits = 0;
    path.delete();
    o = 6'h00;
    lowRun = 0;

    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 59) == 0);
      if (lowRun == 0 && $urandom_range(0, 24) == 0) lowRun = $urandom_range(3, 7);
      if (lowRun > 0) begin
        m = 1'b0;
        lowRun--;
      end else begin
        m = ($urandom_range(0, 9) < 7);
      end
      if (step == "FETCH") begin
        if ($urandom_range(0, 7) == 0) o = 6'($urandom_range(0, 63));
        else o = legalOps[$urandom_range(0, 11)];
      end
      applyStimulus(r, o, m);
      @(negedge clk);
      checkOutput($sformatf("rand%0d_%s", i, step), expOut(step, o, m, r, waits));
      modelStep(r, o, m);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
